// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one word request at a time,
// holds the returned word (with its PC and PC+4) until decode accepts it,
// and absorbs redirects from execute without ever handing decode a stale word.
module fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        pc_redirect,
   input  logic [31:0] pc_target,
   output logic [31:0] instruction,
   output logic [31:0] instr_pc,
   output logic [31:0] instr_pc_plus4,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic        fetch_fault
);

   // Fetch sequencer states.
   localparam logic [2:0] S_IDLE  = 3'd0;  // first cycle out of reset
   localparam logic [2:0] S_REQ   = 3'd1;  // request strobe on the bus
   localparam logic [2:0] S_WAIT  = 3'd2;  // waiting for the response
   localparam logic [2:0] S_HOLD  = 3'd3;  // word held for decode
   localparam logic [2:0] S_DRAIN = 3'd4;  // discarding one outstanding response
   localparam logic [2:0] S_FAULT = 3'd5;  // misaligned target, stuck until reset

   logic [2:0]  state_q;
   logic [2:0]  state_d;
   logic [31:0] pc_q;
   logic [31:0] pc_d;
   logic [31:0] pc_plus4;

   logic [31:0] instruction_d;
   logic [31:0] instr_pc_d;
   logic [31:0] instr_pc_plus4_d;
   logic        instr_valid_d;
   logic        fetch_fault_d;

   logic        redirect_live;
   logic        target_aligned;

   // 32-bit unsigned add; carry out is dropped so the PC wraps to zero.
   assign pc_plus4 = pc_q + 32'd4;

   // A redirect means nothing once the block has faulted.
   assign redirect_live  = pc_redirect && (state_q != S_FAULT);
   assign target_aligned = (pc_target[1:0] == 2'b00);

   // Bus request is a pure decode of the state; the address is always the PC.
   assign imem_req  = (state_q == S_REQ);
   assign imem_addr = pc_q;

   // Next-state and next-output decision: redirect first, then normal sequencing.
   always_comb begin
      // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
      state_d          = state_q;
      pc_d             = pc_q;
      instruction_d    = instruction;
      instr_pc_d       = instr_pc;
      instr_pc_plus4_d = instr_pc_plus4;
      instr_valid_d    = instr_valid;
      fetch_fault_d    = fetch_fault;

      if (redirect_live && !target_aligned) begin
         // Misaligned target: PC is left alone and the block parks in FAULT.
         // Any response still in flight is ignored there.
         fetch_fault_d = 1'b1;
         instr_valid_d = 1'b0;
         instruction_d = NOP_INSTR;
         state_d       = S_FAULT;
      end else if (redirect_live) begin
         pc_d = pc_target;
         case (state_q)
            S_IDLE: state_d = S_REQ;
            // The request on the bus this cycle will still be answered.
            S_REQ:  state_d = S_DRAIN;
            // A response arriving with the redirect is simply dropped.
            S_WAIT: state_d = imem_rvalid ? S_REQ : S_DRAIN;
            S_HOLD: begin
               // Redirect beats a same-cycle accept: the held word is discarded.
               instr_valid_d = 1'b0;
               instruction_d = NOP_INSTR;
               state_d       = S_REQ;
            end
            S_DRAIN: state_d = imem_rvalid ? S_REQ : S_DRAIN;
            default: state_d = S_IDLE;
         endcase
      end else begin
         case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ:  state_d = S_WAIT;
            S_WAIT: begin
               if (imem_rvalid) begin
                  instruction_d    = imem_rdata;
                  instr_pc_d       = pc_q;
                  instr_pc_plus4_d = pc_plus4;
                  instr_valid_d    = 1'b1;
                  pc_d             = pc_plus4;
                  state_d          = S_HOLD;
               end
            end
            S_HOLD: begin
               if (instr_ready) begin
                  instr_valid_d = 1'b0;
                  instruction_d = NOP_INSTR;
                  state_d       = S_REQ;
               end
            end
            S_DRAIN: begin
               if (imem_rvalid) begin
                  state_d = S_REQ;
               end
            end
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_IDLE;
         endcase
      end
   end

   // State, PC and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values, independent of statement order.
      if (!rst_n) begin
         state_q        <= S_IDLE;
         pc_q           <= RESET_PC;
         instruction    <= NOP_INSTR;
         instr_pc       <= RESET_PC;
         instr_pc_plus4 <= RESET_PC + 32'd4;
         instr_valid    <= 1'b0;
         fetch_fault    <= 1'b0;
      end else begin
         state_q        <= state_d;
         pc_q           <= pc_d;
         instruction    <= instruction_d;
         instr_pc       <= instr_pc_d;
         instr_pc_plus4 <= instr_pc_plus4_d;
         instr_valid    <= instr_valid_d;
         fetch_fault    <= fetch_fault_d;
      end
   end

endmodule
